// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with round-robin tie breaking,
// split-transaction support and a hold-time watchdog that revokes a grant
// held for too long. All outputs are registered.
`timescale 1ns/1ps

module bus_arbiter #(
    parameter int unsigned   CW      = 8,
    parameter logic [CW-1:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic breq1,
    input  logic breq2,
    input  logic tx_done,
    input  logic split_en,
    input  logic slave_valid,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic split_active,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    // Master encoding for msel, last and split_master: 0 = master 1, 1 = master 2.
    logic          split_master;
    logic          split_master_next;
    logic          last;
    logic          last_next;
    logic          msel_next;
    logic          split_active_next;
    logic          timeout_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic          elig1;
    logic          elig2;
    logic          grant_valid;
    logic          grant_sel;
    logic          req_held;
    logic          hold_expired;

    // Next-state and next-register computation: arbitration in IDLE, release checks while granted.
    always_comb begin
        state_next        = state;
        msel_next         = msel;
        last_next         = last;
        split_active_next = split_active;
        split_master_next = split_master;
        cnt_next          = cnt;
        timeout_next      = 1'b0;
        grant_valid       = 1'b0;
        grant_sel         = 1'b0;
        req_held          = 1'b0;
        hold_expired      = (cnt == TIMEOUT);

        // The master whose read was split may not re-arbitrate; it only gets
        // the bus back through the split return path.
        elig1 = breq1 && !(split_active && (split_master == 1'b0));
        elig2 = breq2 && !(split_active && (split_master == 1'b1));

        case (state)
            IDLE: begin
                if (split_active && slave_valid) begin
                    grant_valid       = 1'b1;
                    grant_sel         = split_master;
                    split_active_next = 1'b0;
                end else if (elig1 && elig2) begin
                    grant_valid = 1'b1;
                    grant_sel   = ~last;
                end else if (elig1) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b0;
                end else if (elig2) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b1;
                end

                if (grant_valid) begin
                    state_next = grant_sel ? GRANT2 : GRANT1;
                    msel_next  = grant_sel;
                    last_next  = grant_sel;
                    cnt_next   = '0;
                end
            end

            GRANT1, GRANT2: begin
                req_held = (state == GRANT1) ? breq1 : breq2;

                if (tx_done || !req_held || split_en || hold_expired) begin
                    // Always drop back to IDLE so grants never run back to back.
                    state_next = IDLE;
                    if (split_en) begin
                        split_active_next = 1'b1;
                        split_master_next = (state == GRANT2);
                    end else if (hold_expired) begin
                        timeout_next = 1'b1;
                    end
                end else if (cnt != '1) begin
                    cnt_next = cnt + CW'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears any grant or pending split immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bgrant1      <= 1'b0;
            bgrant2      <= 1'b0;
            msel         <= 1'b0;
            split_active <= 1'b0;
            split_master <= 1'b0;
            last         <= 1'b1;
            cnt          <= '0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            bgrant1      <= (state_next == GRANT1);
            bgrant2      <= (state_next == GRANT2);
            msel         <= msel_next;
            split_active <= split_active_next;
            split_master <= split_master_next;
            last         <= last_next;
            cnt          <= cnt_next;
            timeout      <= timeout_next;
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: maximum cycles a grant is held without release.
REQ-002 SHALL have parameter CW, default 8: width of the hold counter; TIMEOUT SHALL fit in CW bits.
REQ-003 clk  input  1  the single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 breq1  input  1  bus request from master 1.
REQ-006 breq2  input  1  bus request from master 2.
REQ-007 tx_done  input  1  one-cycle pulse: the granted master's transaction is complete.
REQ-008 split_en  input  1  pulse from the split-capable slave port: the current read is split.
REQ-009 slave_valid  input  1  level from the split-capable slave port: split read data is ready.
REQ-010 bgrant1  output  1  registered bus grant to master 1.
REQ-011 bgrant2  output  1  registered bus grant to master 2.
REQ-012 msel  output  1  bus mux select: 0 = master 1, 1 = master 2; held at the last granted master while idle.
REQ-013 split_active  output  1  high while a split transaction is pending.
REQ-014 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-015 SHALL implement the states IDLE, GRANT1 and GRANT2; at most one of bgrant1/bgrant2 SHALL ever be high.
REQ-016 SHALL keep the registers split_master (1 bit), last (1 bit, last granted master) and cnt (CW bits).
REQ-017 In IDLE, arbitration priority SHALL be:
  - (a) split return: split_active=1 and slave_valid=1 -> grant split_master, clear split_active;
  - (b) one eligible requester -> grant it;
  - (c) both eligible -> grant the master that is not last.
REQ-018 A requester SHALL be ineligible while split_active=1 and split_master equals that requester.
REQ-019 Grant latency SHALL be one cycle: breq sampled high in IDLE at edge n -> bgrant high after edge n+1.
REQ-020 On every grant, the block SHALL set msel and last to the granted master and clear cnt.
REQ-021 In GRANTx, release to IDLE on the next edge SHALL happen on any of: tx_done=1, breqx=0, split_en=1, or cnt=TIMEOUT.
REQ-022 In GRANTx with none of those conditions, cnt SHALL increment by 1 per cycle and SHALL NOT wrap.
REQ-023 On release by split_en, the block SHALL set split_active=1 and split_master=x.
REQ-024 split_en SHALL take precedence when it coincides with tx_done or timeout: it is recorded as a split and timeout SHALL NOT pulse.
REQ-025 On release by cnt=TIMEOUT without split_en, timeout SHALL pulse high for exactly one cycle.
REQ-026 Every release SHALL pass through at least one IDLE cycle; back-to-back grants without a gap are forbidden.
REQ-027 split_en received in IDLE SHALL be ignored.
REQ-028 slave_valid while split_active=0 SHALL be ignored.
REQ-029 slave_valid while the other master holds the bus SHALL wait until that master releases.
REQ-030 A split return grant SHALL be given even if breq of split_master is low; it is then released by the normal rules of REQ-021.

Reset
REQ-031 While reset=0, the block SHALL immediately set: state=IDLE, bgrant1=0, bgrant2=0, msel=0, split_active=0, split_master=0, last=1, cnt=0, timeout=0.
REQ-032 Reset asserted mid-grant or mid-split SHALL discard the grant and any pending split with no residual pulse.
REQ-033 After reset is released, the first grant SHALL follow REQ-019.

Verification
REQ-034 Single request: breq1=1 from idle -> bgrant1=1 one cycle later, msel=0; tx_done pulse -> bgrant1=0 next cycle.
REQ-035 Round-robin: breq1=breq2=1 continuously, tx_done every 4th grant cycle -> grants alternate 1,2,1,2 with one idle cycle between grants.
REQ-036 Split: master 1 granted, split_en pulse -> bgrant1=0, split_active=1, bgrant2 granted if breq2=1; slave_valid=1 after master 2 releases -> bgrant1=1, split_active=0.
REQ-037 Timeout: TIMEOUT=4, breq2 held high, no tx_done -> bgrant2 high 5 cycles, then timeout=1 for one cycle and bgrant2=0.
REQ-038 Collision: split_en and tx_done in the same cycle -> split_active=1 and timeout=0.
REQ-039 Async reset: reset=0 mid-split between edges -> all outputs 0 immediately; after release, breq2 alone -> bgrant2 one cycle later.
